hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
Owns the architectural HI/LO register pair and produces the hi/lo values the ALU reads for MFHI/MFLO. Executes MULT/MULTU/DIV/DIVU iteratively and commits results to HI/LO. MTHI/MTLO writes land here in one cycle. Sits in EX beside the ALU and raises a stall request toward the pipeline hazard unit while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width
ITER, 32, iteration edges per mul/div (must equal WIDTH)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  synchronous active-low reset
op_valid  in  1  op/src valid this cycle
op  in  3  MD_OP_* code from defines.vh
src_a  in  32  rs value (dividend / multiplicand / MT source)
src_b  in  32  rt value (divisor / multiplier)
flush  in  1  abort in-flight op, discard result
hi_out  out  32  current HI, registered
lo_out  out  32  current LO, registered
busy  out  1  mul/div in progress
stall_req  out  1  busy | (op_valid & op is mul/div)
done  out  1  one-cycle pulse after HI/LO commit

Behaviour:
- Reset (resetn=0 at edge): hi=lo=0, busy=0, done=0, state=IDLE, counter=0; any in-flight op is dropped.
- States: IDLE, MUL, DIV. Transitions occur only at rising clk.
- Accept: IDLE & op_valid & !flush. op_valid while busy is ignored; upstream holds the instruction via stall_req.
- MTHI/MTLO: accepted at edge E0; hi/lo = src_a visible after E0. State stays IDLE, busy stays 0, done stays 0.
- MULT/MULTU/DIV/DIVU:
  - Accept edge E0 latches operands. Signed ops latch absolute values plus sign flags.
  - State goes to MUL/DIV; busy=1 from E0.
  - Iteration edges E1..E32: one shift-add or restoring shift-subtract step per edge; counter 0..31.
  - At E32: final step, sign correction, HI/LO written; busy=0; done=1 for the following cycle only.
  - Total latency from accept edge to HI/LO update: 32 edges.
- Multiply: 64-bit product; HI=product[63:32], LO=product[31:0]. Signed result is the two's-complement negation if operand signs differ.
- Divide: LO=quotient, HI=remainder.
  - Signed: quotient is negative if operand signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0. No trap.
- Divide by zero (DIV or DIVU): full 32 edges still taken; HI=src_a unmodified, LO=0xFFFFFFFF; no sign correction.
- flush:
  - Priority over accept and over iteration.
  - When busy: next edge returns to IDLE, busy=0, done=0, HI/LO unchanged.
  - Same-edge flush and final step (E32): flush wins, no commit.
  - flush in IDLE blocks the concurrent op_valid, including MTHI/MTLO.
- stall_req is combinational. It is asserted on the accept cycle of a mul/div and deasserts in the cycle after E32. The pipeline then advances and can read the new HI/LO via the ALU.
- hi_out/lo_out change only at: reset, MT accept edge, mul/div commit edge.
- Unknown op codes with op_valid: ignored, no state change.

Decomposition:
- defines.vh gains MD_OP_MULT=3'd0, MD_OP_MULTU=3'd1, MD_OP_DIV=3'd2, MD_OP_DIVU=3'd3, MD_OP_MTHI=3'd4, MD_OP_MTLO=3'd5, and state encodings MD_IDLE/MD_MUL/MD_DIV.
- One sub-module, div_iter: unsigned restoring divider step datapath (remainder/quotient shift register, counter-driven) with start/abort/done.
- Multiply shift-add and sign correction stay in hilo_muldiv.

Test Plan:
1. Hold resetn=0 two edges, then release -> hi_out=lo_out=0, busy=0, done=0, stall_req=0.
2. MULT src_a=0xFFFFFFFF, src_b=0x2 -> after 32 edges HI=0xFFFFFFFF, LO=0xFFFFFFFE, done pulses one cycle. MULTU same operands -> HI=0x1, LO=0xFFFFFFFE.
3. DIV src_a=0xFFFFFFF9 (-7), src_b=0x2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU src_a=7, src_b=2 -> LO=3, HI=1.
4. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 0x1234 / 0 -> HI=0x1234, LO=0xFFFFFFFF after 32 edges.
5. MTHI 0x11111111 while busy -> ignored. Flush asserted on iteration edge E10 of a DIV -> busy=0 next edge, HI/LO keep prior values, no done pulse.
6. MTLO 0xA5A5A5A5 in IDLE -> lo_out=0xA5A5A5A5 after one edge, hi_out unchanged, busy/stall_req stay 0. Repeat with flush=1 on the same cycle -> lo_out unchanged.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared opcodes and state encoding for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;
  localparam logic [2:0] MD_OP_MTHI  = 3'd4;
  localparam logic [2:0] MD_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_t;

  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// Unsigned restoring divider, one quotient bit per clock.
// quotient/remainder show the result of the step taken at the next edge.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] rem, quo, dvs;
  logic [CW-1:0]    cnt;
  logic             run;
  logic [WIDTH:0]   trial, diff;

  // Bit WIDTH of diff doubles as the borrow flag of the trial subtraction.
  always_comb begin
    trial = {rem, quo[WIDTH-1]};
    diff  = trial - {1'b0, dvs};
    if (diff[WIDTH]) begin
      remainder = trial[WIDTH-1:0];
      quotient  = {quo[WIDTH-2:0], 1'b0};
    end else begin
      remainder = diff[WIDTH-1:0];
      quotient  = {quo[WIDTH-2:0], 1'b1};
    end
    done = run & (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (abort) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      rem <= remainder;
      quo <= quotient;
      cnt <= cnt + 1'b1;
      if (done) begin
        run <= 1'b0;
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with iterative MULT/MULTU/DIV/DIVU and MTHI/MTLO writes.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             stall_req,
  output logic             done
);

  localparam int CW = $clog2(ITER);

  md_state_t          state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod, prod_nx, prod_fix;
  logic [WIDTH:0]     psum;
  logic [WIDTH-1:0]   mcand, raw_a, hi, lo;
  logic [WIDTH-1:0]   a_abs, b_abs, div_q, div_r, q_fix, r_fix;
  logic               neg_res, neg_rem, div0;
  logic               signed_op, a_neg, b_neg;
  logic               accept, mul_last, mul_commit, div_start, div_done, div_commit;

  assign hi_out = hi;
  assign lo_out = lo;

  always_comb begin
    signed_op = (op == MD_OP_MULT) || (op == MD_OP_DIV);
    a_neg     = signed_op & src_a[WIDTH-1];
    b_neg     = signed_op & src_b[WIDTH-1];
    a_abs     = a_neg ? ('0 - src_a) : src_a;
    b_abs     = b_neg ? ('0 - src_b) : src_b;
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= MD_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      MD_IDLE: begin
        if (accept && (op == MD_OP_MULT || op == MD_OP_MULTU)) state_nx = MD_MUL;
        else if (accept && (op == MD_OP_DIV || op == MD_OP_DIVU)) state_nx = MD_DIV;
      end
      MD_MUL:  if (flush || mul_last) state_nx = MD_IDLE;
      MD_DIV:  if (flush || div_done) state_nx = MD_IDLE;
      default: state_nx = MD_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != MD_IDLE);
    stall_req  = busy | (op_valid & is_muldiv(op));
    accept     = (state == MD_IDLE) & op_valid & ~flush;
    mul_last   = (state == MD_MUL) & (cnt == CW'(ITER - 1));
    mul_commit = mul_last & ~flush;
    div_start  = accept & ((op == MD_OP_DIV) || (op == MD_OP_DIVU));
    div_commit = (state == MD_DIV) & div_done & ~flush;
  end

  // Shift-add: multiplier sits in the low half and shifts out as the product shifts in.
  always_comb begin
    psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nx  = {psum, prod[WIDTH-1:1]};
    prod_fix = neg_res ? ('0 - prod_nx) : prod_nx;
    q_fix    = neg_res ? ('0 - div_q) : div_q;
    r_fix    = neg_rem ? ('0 - div_r) : div_r;
  end

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .abort     (flush),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      cnt     <= '0;
      prod    <= '0;
      mcand   <= '0;
      raw_a   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else begin
      done <= mul_commit | div_commit;
      if (accept) begin
        if (op == MD_OP_MTHI) hi <= src_a;
        if (op == MD_OP_MTLO) lo <= src_a;
        mcand   <= a_abs;
        prod    <= {{WIDTH{1'b0}}, b_abs};
        raw_a   <= src_a;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        div0    <= (src_b == '0);
        cnt     <= '0;
      end
      if (state == MD_MUL) begin
        prod <= prod_nx;
        cnt  <= (flush || mul_last) ? '0 : cnt + 1'b1;
      end
      if (mul_commit) {hi, lo} <= prod_fix;
      if (div_commit) begin
        if (div0) begin
          hi <= raw_a;
          lo <= '1;
        end else begin
          hi <= r_fix;
          lo <= q_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed table, corner sequences, random vs arithmetic model.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, op_valid, flush;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic [31:0] hi_out, lo_out;
  logic        busy, stall_req, done;

  int tests = 0;
  int fails = 0;
  logic [31:0] mhi, mlo;

  always #5 clk = ~clk;

  hilo_muldiv #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy),
    .stall_req(stall_req), .done(done)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      MD_OP_MULT:  return 64'(sa * sb);
      MD_OP_MULTU: return ua * ub;
      MD_OP_DIV:   if (b == 32'h0) return {a, 32'hFFFFFFFF};
                   else return {32'(sa % sb), 32'(sa / sb)};
      default:     if (b == 32'h0) return {a, 32'hFFFFFFFF};
                   else return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; src_a = a; src_b = b; op_valid = 1'b1;
    #1;
    check("stall_on_accept", 64'(stall_req), 64'(o <= MD_OP_DIVU));
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic run_muldiv(input string tag, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp);
    int edges;
    logic [63:0] prev;
    prev = {mhi, mlo};
    start_op(o, a, b);
    check("busy_after_accept", 64'(busy), 64'(1));
    edges = 0;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 16) check("hilo_hold_midop", {hi_out, lo_out}, prev);
    end
    check("latency", 64'(edges), 64'(32));
    check(tag, {hi_out, lo_out}, exp);
    check("idle_after_commit", 64'({busy, stall_req}), 64'(0));
    @(posedge clk); #1;
    check("done_pulse_width", 64'(done), 64'(0));
    {mhi, mlo} = exp;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    resetn = 1'b0; op_valid = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("reset_hilo", {hi_out, lo_out}, 64'h0);
    check("reset_ctrl", 64'({busy, done, stall_req}), 64'(0));
    mhi = '0; mlo = '0;

    vecs[0] = '{MD_OP_MULT,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1] = '{MD_OP_MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{MD_OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{MD_OP_DIVU,  32'h7,        32'h2,        32'h00000001, 32'h00000003};
    vecs[4] = '{MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{MD_OP_DIVU,  32'h1234,     32'h0,        32'h00001234, 32'hFFFFFFFF};
    vecs[6] = '{MD_OP_DIV,   32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{MD_OP_DIV,   32'hFFFFFF9C, 32'h0,        32'hFFFFFF9C, 32'hFFFFFFFF};
    vecs[8] = '{MD_OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9] = '{MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    for (int i = 0; i < 10; i++)
      run_muldiv($sformatf("vec%0d_hilo", i), vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});

    // MTLO in idle, then blocked by a same-cycle flush
    @(negedge clk);
    op = MD_OP_MTLO; src_a = 32'hA5A5A5A5; op_valid = 1'b1;
    #1 check("mtlo_no_stall", 64'(stall_req), 64'(0));
    @(posedge clk); #1 op_valid = 1'b0;
    check("mtlo_write", {hi_out, lo_out}, {mhi, 32'hA5A5A5A5});
    check("mtlo_ctrl", 64'({busy, done, stall_req}), 64'(0));
    mlo = 32'hA5A5A5A5;
    @(negedge clk);
    op = MD_OP_MTLO; src_a = 32'h5A5A5A5A; op_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 op_valid = 1'b0; flush = 1'b0;
    check("mtlo_flushed", {hi_out, lo_out}, {mhi, mlo});
    @(negedge clk);
    op = MD_OP_MTHI; src_a = 32'hCAFEF00D; op_valid = 1'b1;
    @(posedge clk); #1 op_valid = 1'b0;
    check("mthi_write", {hi_out, lo_out}, {32'hCAFEF00D, mlo});
    mhi = 32'hCAFEF00D;

    // unknown opcode is ignored
    @(negedge clk);
    op = 3'd6; src_a = 32'h77777777; op_valid = 1'b1;
    #1 check("unknown_no_stall", 64'(stall_req), 64'(0));
    @(posedge clk); #1 op_valid = 1'b0;
    check("unknown_hilo", {hi_out, lo_out}, {mhi, mlo});
    check("unknown_busy", 64'(busy), 64'(0));

    // MTHI while busy is ignored; flush on E10 of a DIV discards it
    start_op(MD_OP_DIV, 32'd100, 32'd7);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 3) begin op = MD_OP_MTHI; src_a = 32'h11111111; op_valid = 1'b1; end
      else op_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("mthi_while_busy", {hi_out, lo_out}, {mhi, mlo});
    check("busy_before_flush", 64'(busy), 64'(1));
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_e10_busy", 64'(busy), 64'(0));
    check("flush_e10_hilo", {hi_out, lo_out}, {mhi, mlo});
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1; end
    check("flush_e10_no_done", 64'(seen), 64'(0));
    check("flush_e10_hilo_late", {hi_out, lo_out}, {mhi, mlo});

    // flush coinciding with the final step wins
    start_op(MD_OP_MULTU, 32'd3, 32'd5);
    repeat (31) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_e32_hilo", {hi_out, lo_out}, {mhi, mlo});
    check("flush_e32_ctrl", 64'({busy, done}), 64'(0));
    run_muldiv("after_flush_multu", MD_OP_MULTU, 32'd3, 32'd5, 64'd15);

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      if (i % 4 == 1) ra = ra >> $urandom_range(0, 31);
      rb = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 31);
      run_muldiv($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb), ro, ra, rb, ref_md(ro, ra, rb));
    end

    // reset in flight clears HI/LO and drops the operation
    start_op(MD_OP_MULT, 32'd12345, 32'd678);
    repeat (5) @(posedge clk);
    @(negedge clk) resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    check("midop_reset_hilo", {hi_out, lo_out}, 64'h0);
    check("midop_reset_busy", 64'(busy), 64'(0));
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1; end
    check("midop_reset_no_done", 64'(seen), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
